// File: rtl/idma_axi_lite_beat_sequencer_pkg.sv
// Shared types for the AXI-Lite beat sequencer: transfer request, AX/datapath
// request and response structs, and the controller state encoding.
package idma_pkg;

  localparam int unsigned PkgDataWidth = 32;
  localparam int unsigned PkgAddrWidth = 32;
  localparam int unsigned PkgLenWidth  = 32;
  localparam int unsigned PkgStrbWidth = PkgDataWidth / 8;
  localparam int unsigned PkgOffWidth  = $clog2(PkgStrbWidth);

  typedef logic [PkgAddrWidth-1:0] addr_t;
  typedef logic [PkgLenWidth-1:0]  len_t;
  typedef logic [PkgOffWidth-1:0]  off_t;

  typedef struct packed {
    addr_t src_addr;
    addr_t dst_addr;
    len_t  length;
  } req_t;

  typedef struct packed {
    addr_t      addr;
    logic [2:0] prot;
  } ax_req_t;

  typedef struct packed {
    off_t offset;
    off_t tailer;
    off_t shift;
  } r_dp_req_t;

  typedef struct packed {
    off_t offset;
    off_t tailer;
  } w_dp_req_t;

  typedef struct packed {
    logic [1:0] resp;
  } dp_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/idma_axi_lite_beat_sequencer_if.sv
// Bundles the transfer, AR/AW meta, datapath request and datapath response
// handshakes of the beat sequencer; slave is the sequencer side.
interface idma_axi_lite_beat_sequencer_if;
  import idma_pkg::*;

  req_t      req_i;
  logic      req_valid_i;
  logic      req_ready_o;
  logic      rsp_error_o;
  logic      rsp_valid_o;
  logic      rsp_ready_i;
  ax_req_t   ar_req_o;
  logic      ar_valid_o;
  logic      ar_ready_i;
  ax_req_t   aw_req_o;
  logic      aw_valid_o;
  logic      aw_ready_i;
  r_dp_req_t r_dp_req_o;
  logic      r_dp_valid_o;
  logic      r_dp_ready_i;
  w_dp_req_t w_dp_req_o;
  logic      w_dp_valid_o;
  logic      w_dp_ready_i;
  dp_rsp_t   r_dp_rsp_i;
  logic      r_dp_rsp_valid_i;
  logic      r_dp_rsp_ready_o;
  dp_rsp_t   w_dp_rsp_i;
  logic      w_dp_rsp_valid_i;
  logic      w_dp_rsp_ready_o;

  modport slave (
    input  req_i, req_valid_i, rsp_ready_i, ar_ready_i, aw_ready_i,
           r_dp_ready_i, w_dp_ready_i, r_dp_rsp_i, r_dp_rsp_valid_i,
           w_dp_rsp_i, w_dp_rsp_valid_i,
    output req_ready_o, rsp_error_o, rsp_valid_o, ar_req_o, ar_valid_o,
           aw_req_o, aw_valid_o, r_dp_req_o, r_dp_valid_o, w_dp_req_o,
           w_dp_valid_o, r_dp_rsp_ready_o, w_dp_rsp_ready_o
  );

  modport master (
    output req_i, req_valid_i, rsp_ready_i, ar_ready_i, aw_ready_i,
           r_dp_ready_i, w_dp_ready_i, r_dp_rsp_i, r_dp_rsp_valid_i,
           w_dp_rsp_i, w_dp_rsp_valid_i,
    input  req_ready_o, rsp_error_o, rsp_valid_o, ar_req_o, ar_valid_o,
           aw_req_o, aw_valid_o, r_dp_req_o, r_dp_valid_o, w_dp_req_o,
           w_dp_valid_o, r_dp_rsp_ready_o, w_dp_rsp_ready_o
  );

endinterface

// File: rtl/idma_axi_lite_beat_sequencer.sv
// Splits a 1D transfer into AXI-Lite AR/AW beats and datapath requests; first beat one cycle
// after accept, each stream held until its ready, AR/AW throttled by outstanding responses.
module idma_axi_lite_beat_sequencer
  import idma_pkg::*;
#(
  parameter int unsigned DataWidth      = PkgDataWidth,
  parameter int unsigned AddrWidth      = PkgAddrWidth,
  parameter int unsigned LenWidth       = PkgLenWidth,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic busy_o,
  idma_axi_lite_beat_sequencer_if.slave bus
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned CntWidth  = LenWidth + 1;
  localparam int unsigned OutWidth  = 4;

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [OutWidth-1:0] out_t;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_base_q, dst_base_q;
  off_t                 src_off_q, dst_off_q, r_tail_q, w_tail_q, shift_q;
  cnt_t                 nr_q, nw_q;
  cnt_t                 ar_cnt_q, aw_cnt_q, rdp_cnt_q, wdp_cnt_q, r_rsp_cnt_q, w_rsp_cnt_q;
  out_t                 ar_out_q, aw_out_q;
  logic                 err_q;

  logic req_hs, ar_hs, aw_hs, rdp_hs, wdp_hs, r_rsp_hs, w_rsp_hs;
  off_t src_off, dst_off;
  cnt_t r_span, w_span;

  // Beat counts use one extra bit so offset+length cannot wrap.
  assign src_off = bus.req_i.src_addr[OffWidth-1:0];
  assign dst_off = bus.req_i.dst_addr[OffWidth-1:0];
  assign r_span  = cnt_t'(src_off) + cnt_t'(bus.req_i.length);
  assign w_span  = cnt_t'(dst_off) + cnt_t'(bus.req_i.length);

  assign bus.req_ready_o      = (state_q == IDLE);
  assign bus.rsp_valid_o      = (state_q == DONE);
  assign bus.rsp_error_o      = err_q;
  assign bus.r_dp_rsp_ready_o = (state_q == BUSY);
  assign bus.w_dp_rsp_ready_o = (state_q == BUSY);
  assign busy_o               = (state_q != IDLE);

  assign bus.ar_valid_o   = (state_q == BUSY) && (ar_cnt_q < nr_q) && (ar_out_q != out_t'(NumOutstanding));
  assign bus.aw_valid_o   = (state_q == BUSY) && (aw_cnt_q < nw_q) && (aw_out_q != out_t'(NumOutstanding));
  assign bus.r_dp_valid_o = (state_q == BUSY) && (rdp_cnt_q < nr_q);
  assign bus.w_dp_valid_o = (state_q == BUSY) && (wdp_cnt_q < nw_q);

  assign bus.ar_req_o.addr = src_base_q + AddrWidth'(ar_cnt_q << OffWidth);
  assign bus.ar_req_o.prot = 3'b000;
  assign bus.aw_req_o.addr = dst_base_q + AddrWidth'(aw_cnt_q << OffWidth);
  assign bus.aw_req_o.prot = 3'b000;

  assign bus.r_dp_req_o.offset = (rdp_cnt_q == '0) ? src_off_q : '0;
  assign bus.r_dp_req_o.tailer = (rdp_cnt_q == nr_q - cnt_t'(1)) ? r_tail_q : '0;
  assign bus.r_dp_req_o.shift  = shift_q;
  assign bus.w_dp_req_o.offset = (wdp_cnt_q == '0) ? dst_off_q : '0;
  assign bus.w_dp_req_o.tailer = (wdp_cnt_q == nw_q - cnt_t'(1)) ? w_tail_q : '0;

  assign req_hs   = bus.req_valid_i && bus.req_ready_o;
  assign ar_hs    = bus.ar_valid_o && bus.ar_ready_i;
  assign aw_hs    = bus.aw_valid_o && bus.aw_ready_i;
  assign rdp_hs   = bus.r_dp_valid_o && bus.r_dp_ready_i;
  assign wdp_hs   = bus.w_dp_valid_o && bus.w_dp_ready_i;
  assign r_rsp_hs = bus.r_dp_rsp_valid_i && bus.r_dp_rsp_ready_o;
  assign w_rsp_hs = bus.w_dp_rsp_valid_i && bus.w_dp_rsp_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_hs) state_d = (bus.req_i.length == '0) ? DONE : BUSY;
      BUSY: if ((r_rsp_cnt_q + cnt_t'(r_rsp_hs) == nr_q) &&
                (w_rsp_cnt_q + cnt_t'(w_rsp_hs) == nw_q)) state_d = DONE;
      DONE: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      src_off_q   <= '0;
      dst_off_q   <= '0;
      r_tail_q    <= '0;
      w_tail_q    <= '0;
      shift_q     <= '0;
      nr_q        <= '0;
      nw_q        <= '0;
      ar_cnt_q    <= '0;
      aw_cnt_q    <= '0;
      rdp_cnt_q   <= '0;
      wdp_cnt_q   <= '0;
      r_rsp_cnt_q <= '0;
      w_rsp_cnt_q <= '0;
      ar_out_q    <= '0;
      aw_out_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        src_base_q  <= {bus.req_i.src_addr[AddrWidth-1:OffWidth], OffWidth'(0)};
        dst_base_q  <= {bus.req_i.dst_addr[AddrWidth-1:OffWidth], OffWidth'(0)};
        src_off_q   <= src_off;
        dst_off_q   <= dst_off;
        r_tail_q    <= r_span[OffWidth-1:0];
        w_tail_q    <= w_span[OffWidth-1:0];
        shift_q     <= src_off - dst_off;
        nr_q        <= (r_span + cnt_t'(StrbWidth - 1)) >> OffWidth;
        nw_q        <= (w_span + cnt_t'(StrbWidth - 1)) >> OffWidth;
        ar_cnt_q    <= '0;
        aw_cnt_q    <= '0;
        rdp_cnt_q   <= '0;
        wdp_cnt_q   <= '0;
        r_rsp_cnt_q <= '0;
        w_rsp_cnt_q <= '0;
        err_q       <= 1'b0;
      end else begin
        if (ar_hs)    ar_cnt_q    <= ar_cnt_q + cnt_t'(1);
        if (aw_hs)    aw_cnt_q    <= aw_cnt_q + cnt_t'(1);
        if (rdp_hs)   rdp_cnt_q   <= rdp_cnt_q + cnt_t'(1);
        if (wdp_hs)   wdp_cnt_q   <= wdp_cnt_q + cnt_t'(1);
        if (r_rsp_hs) r_rsp_cnt_q <= r_rsp_cnt_q + cnt_t'(1);
        if (w_rsp_hs) w_rsp_cnt_q <= w_rsp_cnt_q + cnt_t'(1);
        if ((r_rsp_hs && bus.r_dp_rsp_i.resp != 2'b00) ||
            (w_rsp_hs && bus.w_dp_rsp_i.resp != 2'b00)) err_q <= 1'b1;
      end
      if (ar_hs && !r_rsp_hs)      ar_out_q <= ar_out_q + out_t'(1);
      else if (!ar_hs && r_rsp_hs) ar_out_q <= ar_out_q - out_t'(1);
      if (aw_hs && !w_rsp_hs)      aw_out_q <= aw_out_q + out_t'(1);
      else if (!aw_hs && w_rsp_hs) aw_out_q <= aw_out_q - out_t'(1);
    end
  end

endmodule

// File: tb/tb_idma_axi_lite_beat_sequencer.sv
// Directed bench for the beat sequencer: aligned/unaligned transfers, zero length,
// outstanding throttling, sticky error and reset mid-transfer.
module tb_idma_axi_lite_beat_sequencer;
  import idma_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic busy_o;
  int   vectors = 0;
  int   miscompares = 0;

  idma_axi_lite_beat_sequencer_if bus ();

  idma_axi_lite_beat_sequencer #(
    .DataWidth(32), .AddrWidth(32), .LenWidth(32), .NumOutstanding(2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .busy_o(busy_o),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] valids();
    return {bus.ar_valid_o, bus.aw_valid_o, bus.r_dp_valid_o, bus.w_dp_valid_o};
  endfunction

  task automatic idle_inputs();
    bus.req_i            = '0;
    bus.req_valid_i      = 1'b0;
    bus.rsp_ready_i      = 1'b0;
    bus.ar_ready_i       = 1'b0;
    bus.aw_ready_i       = 1'b0;
    bus.r_dp_ready_i     = 1'b0;
    bus.w_dp_ready_i     = 1'b0;
    bus.r_dp_rsp_i       = '0;
    bus.r_dp_rsp_valid_i = 1'b0;
    bus.w_dp_rsp_i       = '0;
    bus.w_dp_rsp_valid_i = 1'b0;
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    @(negedge clk_i);
    bus.req_i       = '{src_addr: s, dst_addr: d, length: l};
    bus.req_valid_i = 1'b1;
    #1;
    chk("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
  endtask

  // All four streams ready; checks the beat presented this cycle.
  task automatic beat(input string tag, input logic [31:0] ar, input logic [31:0] aw,
                      input logic [5:0] r_exp, input logic [3:0] w_exp);
    @(negedge clk_i);
    bus.req_valid_i  = 1'b0;
    bus.ar_ready_i   = 1'b1;
    bus.aw_ready_i   = 1'b1;
    bus.r_dp_ready_i = 1'b1;
    bus.w_dp_ready_i = 1'b1;
    #1;
    chk({tag, "_valids"}, 64'(valids()), 64'hf);
    chk({tag, "_ar_addr"}, 64'(bus.ar_req_o.addr), 64'(ar));
    chk({tag, "_aw_addr"}, 64'(bus.aw_req_o.addr), 64'(aw));
    chk({tag, "_r_dp"}, 64'(bus.r_dp_req_o), 64'(r_exp));
    chk({tag, "_w_dp"}, 64'(bus.w_dp_req_o), 64'(w_exp));
  endtask

  task automatic quiet(input string tag);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    #1;
    chk({tag, "_no_valids"}, 64'(valids()), 64'h0);
  endtask

  task automatic rsps(input logic [1:0] r, input logic [1:0] w);
    @(negedge clk_i);
    bus.r_dp_rsp_valid_i = 1'b1;
    bus.w_dp_rsp_valid_i = 1'b1;
    bus.r_dp_rsp_i.resp  = r;
    bus.w_dp_rsp_i.resp  = w;
    #1;
    chk("dp_rsp_ready", 64'({bus.r_dp_rsp_ready_o, bus.w_dp_rsp_ready_o}), 64'h3);
  endtask

  // Completion: a zero-length request is offered while DONE and must not be taken.
  task automatic finish(input string tag, input logic err);
    @(negedge clk_i);
    bus.r_dp_rsp_valid_i = 1'b0;
    bus.w_dp_rsp_valid_i = 1'b0;
    #1;
    chk({tag, "_rsp_valid_err"}, 64'({bus.rsp_valid_o, bus.rsp_error_o}), 64'({1'b1, err}));
    chk({tag, "_req_ready_done"}, 64'(bus.req_ready_o), 64'd0);
    bus.rsp_ready_i = 1'b1;
    bus.req_i       = '{src_addr: 32'h0, dst_addr: 32'h0, length: 32'h0};
    bus.req_valid_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    chk({tag, "_back_idle"}, 64'({bus.req_ready_o, busy_o, bus.rsp_valid_o}), 64'b100);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_state", 64'({bus.req_ready_o, busy_o, bus.rsp_valid_o, valids()}), 64'b100_0000);
    rst_i = 1'b0;

    // Aligned, two beats each side.
    start(32'h100, 32'h200, 32'd8);
    beat("al_b0", 32'h100, 32'h200, 6'b00_00_00, 4'b00_00);
    beat("al_b1", 32'h104, 32'h204, 6'b00_00_00, 4'b00_00);
    quiet("al");
    rsps(2'd0, 2'd0);
    rsps(2'd0, 2'd0);
    finish("al", 1'b0);

    // Unaligned: so=1, do=3, shift=(1-3) mod 4=2, r tail=6 mod 4=2, w tail=8 mod 4=0.
    start(32'h101, 32'h203, 32'd5);
    beat("ua_b0", 32'h100, 32'h200, 6'b01_00_10, 4'b11_00);
    beat("ua_b1", 32'h104, 32'h204, 6'b00_10_10, 4'b00_00);
    quiet("ua");
    rsps(2'd0, 2'd0);
    rsps(2'd0, 2'd0);
    finish("ua", 1'b0);

    // Zero length completes immediately with no traffic.
    start(32'h300, 32'h400, 32'd0);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    #1;
    chk("len0_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("len0_no_valids", 64'(valids()), 64'h0);
    finish("len0", 1'b0);

    // SLVERR on a write response makes the completion report an error.
    start(32'h100, 32'h200, 32'd8);
    beat("er_b0", 32'h100, 32'h200, 6'b00_00_00, 4'b00_00);
    beat("er_b1", 32'h104, 32'h204, 6'b00_00_00, 4'b00_00);
    rsps(2'd0, 2'd2);
    rsps(2'd0, 2'd0);
    finish("err", 1'b1);

    // Error flag cleared by the next transfer.
    start(32'h100, 32'h200, 32'd8);
    beat("ok_b0", 32'h100, 32'h200, 6'b00_00_00, 4'b00_00);
    beat("ok_b1", 32'h104, 32'h204, 6'b00_00_00, 4'b00_00);
    rsps(2'd0, 2'd0);
    rsps(2'd0, 2'd0);
    finish("ok", 1'b0);

    // Outstanding limit: 4 read beats, no responses, only 2 ARs may issue.
    start(32'h0, 32'h40, 32'd16);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      bus.req_valid_i  = 1'b0;
      bus.ar_ready_i   = 1'b1;
      bus.aw_ready_i   = 1'b0;
      bus.r_dp_ready_i = 1'b0;
      bus.w_dp_ready_i = 1'b0;
      #1;
      if (bus.ar_valid_o) n++;
    end
    chk("ar_hs_count", 64'(n), 64'd2);
    chk("ar_blocked", 64'(bus.ar_valid_o), 64'd0);
    @(negedge clk_i);
    bus.r_dp_rsp_valid_i = 1'b1;
    bus.r_dp_rsp_i.resp  = 2'd0;
    #1;
    chk("ar_blocked_rsp_cycle", 64'(bus.ar_valid_o), 64'd0);
    @(negedge clk_i);
    bus.r_dp_rsp_valid_i = 1'b0;
    #1;
    chk("ar_resumed", 64'(bus.ar_valid_o), 64'd1);
    chk("ar_resumed_addr", 64'(bus.ar_req_o.addr), 64'h8);

    // Reset with one read outstanding abandons the transfer.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_busy_state", 64'({bus.req_ready_o, busy_o, bus.rsp_valid_o, valids()}), 64'b100_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
